sobel_frame_host: RTL and testbench
===================================

Name: sobel_frame_host

Overview:
- Upstream/downstream companion of the Sobel core; acts as the host master on its Wishbone-style slave port.
- Accepts an 8-bit pixel stream (640x480, raster order) and packs 4 pixels per 32-bit word.
- Writes the frame into the core's on-chip memory, pulses the core's start, and waits for done.
- Reads the result region back and emits it as an 8-bit result stream.

Parameters:
- WIDTH, 640, image width in pixels (multiple of 4)
- HEIGHT, 480, image height in lines
- ADR_W, 22, word address width
- IMG_BASE, 22'h000000, word address of first source word
- RES_BASE, 22'h020000, word address of first result word
- ACK_TIMEOUT, 1023, cycles to wait for ack_i (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- frame_go  in  1  start one frame; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last result byte accepted
- pix_valid  in  1  source pixel valid
- pix_data  in  8  source pixel
- pix_ready  out  1  pixel accepted when pix_valid&pix_ready
- res_valid  out  1  result byte valid
- res_data  out  8  result byte
- res_ready  in  1  sink accepts result byte
- cyc_o  out  1  bus cycle to core
- stb_o  out  1  strobe; equals cyc_o
- we_o  out  1  1 = write, 0 = read
- adr_o  out  ADR_W  word address
- dat_o  out  32  write data
- dat_i  in  32  read data from core
- ack_i  in  1  transfer acknowledge from core
- start_o  out  1  one-cycle start pulse to core
- done_i  in  1  core finished (level or pulse)
- err  out  1  sticky bus-timeout flag (0 without the optional feature)

Behaviour:
- Reset (rst_i=0 at a clk_i edge): state IDLE; word/byte counters 0. All outputs 0 except adr_o=IMG_BASE. Aborts any in-flight transfer immediately.
- WORDS = WIDTH*HEIGHT/4 (76800 by default). Counters are sized for WORDS.
- IDLE: frame_go=1 -> FILL, word_cnt=0. frame_go is ignored in all other states.
- FILL: pix_ready=1. Each accepted pixel goes to lane byte_cnt; lane 0 = dat[7:0], lane 3 = dat[31:24]. The 4th byte -> WR on the next cycle with the word registered.
- WR: cyc_o=stb_o=we_o=1, adr_o=IMG_BASE+word_cnt, dat_o=packed word. All held stable until ack_i=1.
  - On ack_i: cyc_o/stb_o drop next cycle.
  - If word_cnt==WORDS-1 -> KICK; else word_cnt+1 -> FILL.
  - pix_ready=0 in WR.
- KICK: cyc_o=0; start_o=1 for exactly one cycle -> WAIT_DONE.
- WAIT_DONE: cyc_o=0. done_i sampled high -> RD with word_cnt=0. done_i is ignored in every other state.
- RD: cyc_o=stb_o=1, we_o=0, adr_o=RES_BASE+word_cnt, held until ack_i. On ack_i: capture dat_i -> EMIT, byte_cnt=0.
- EMIT: res_valid=1, res_data = captured word lane byte_cnt (lane 0 first). Advance on res_ready. After lane 3 is accepted:
  - If word_cnt==WORDS-1: frame_done=1 for one cycle -> IDLE.
  - Else word_cnt+1 -> RD.
- At most one outstanding transfer at any time; cyc_o is never asserted in FILL, KICK, WAIT_DONE or EMIT.
- ack_i outside WR/RD is ignored.
- Address arithmetic is modulo 2^ADR_W.
- Throughput: at best 5 cycles per written word (4 FILL + 1 WR with same-cycle ack).

Optional Feature:
- Macro: SOBEL_FRAME_HOST_TIMEOUT_EN.
- With macro: a cycle counter runs while in WR or RD and clears on ack_i. When it reaches ACK_TIMEOUT:
  - cyc_o/stb_o drop and state -> IDLE.
  - err is set and stays set until reset.
  - frame_done is not pulsed.
- Without macro: WR/RD wait indefinitely; err tied 0.

Decomposition:
- Package sobel_host_pkg:
  - state enum (IDLE, FILL, WR, KICK, WAIT_DONE, RD, EMIT)
  - WORDS constant function
  - ADR_W default
  - lane-index width
- Sub-module pix_pack4: 4-lane byte packer with lane counter and a "word full" flag, reused in reverse as an unpacker via a mode input.

Test Plan:
- Reset mid-frame: rst_i=0 during WR at word 37 -> next cycle cyc_o=0, busy=0, adr_o=IMG_BASE.
- WIDTH=8,HEIGHT=2, pixels 0x00..0x0F:
  - Writes 4 words: adr 0..3, dat 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - Then exactly one start_o pulse.
- Slave delays ack_i 3 cycles per transfer -> adr_o/dat_o/we_o stable all 4 cycles; no duplicate writes.
- done_i held high during FILL (ignored) then pulsed in WAIT_DONE -> RD at adr 0x020000. Read word 0xDDCCBBAA with res_ready toggling every other cycle -> bytes AA,BB,CC,DD in order.
- Last result byte accepted -> frame_done high exactly 1 cycle, busy=0 next cycle. frame_go asserted during EMIT has no effect.
- Macro on, ACK_TIMEOUT=15, ack_i never asserted -> cyc_o drops after 15 cycles in WR, err=1 sticky, frame_done stays 0.

Source files
------------

// File: rtl/sobel_frame_host_pkg.sv
// Shared types and constants for the Sobel frame host: FSM states, word count helper, lane width.
package sobel_host_pkg;

    typedef enum logic [2:0] {
        IDLE, FILL, WR, KICK, WAIT_DONE, RD, EMIT
    } state_t;

    localparam int ADR_W_DEF = 22;
    localparam int LANE_W    = 2;

    function automatic int words(input int w, input int h);
        return (w * h) / 4;
    endfunction

endpackage

// File: rtl/sobel_frame_host_pix_pack4.sv
// 4-lane byte packer; with i_mode=1 the same register and lane counter unpack a loaded word, lane 0 first.
module pix_pack4
    import sobel_host_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mode,
    input  logic        i_push,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    input  logic [31:0] i_word,
    output logic [31:0] o_word,
    output logic [7:0]  o_byte,
    output logic        o_full
);

    logic [31:0]       r_word;
    logic [LANE_W-1:0] r_lane;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_lane <= '0;
        end else if (i_push) begin
            if (!i_mode)
                r_word[8*r_lane +: 8] <= i_byte;
            r_lane <= r_lane + LANE_W'(1);
        end
    end

    // "Full" means the lane about to be pushed is the last one of the word.
    assign o_full = (r_lane == LANE_W'(3));
    assign o_word = r_word;
    assign o_byte = r_word[8*r_lane +: 8];

endmodule

// File: rtl/sobel_frame_host.sv
// Host master for the Sobel core: packs pixels, writes the frame, kicks the core, streams results back.
// Optional bus-timeout with sticky err enabled by SOBEL_FRAME_HOST_TIMEOUT_EN.
module sobel_frame_host
    import sobel_host_pkg::*;
#(
    parameter int               WIDTH       = 640,
    parameter int               HEIGHT      = 480,
    parameter int               ADR_W       = ADR_W_DEF,
    parameter logic [ADR_W-1:0] IMG_BASE    = '0,
    parameter logic [ADR_W-1:0] RES_BASE    = ADR_W'('h020000),
    parameter int               ACK_TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_go,
    output logic             busy,
    output logic             frame_done,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    output logic             pix_ready,
    output logic             res_valid,
    output logic [7:0]       res_data,
    input  logic             res_ready,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [31:0]      dat_o,
    input  logic [31:0]      dat_i,
    input  logic             ack_i,
    output logic             start_o,
    input  logic             done_i,
    output logic             err
);

    localparam int WORDS = words(WIDTH, HEIGHT);
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
`ifdef SOBEL_FRAME_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_word_cnt;
    logic [TO_W-1:0]  r_to;
    logic             r_err, r_frame_done;
    logic             w_xfer, w_last_word, w_pix_acc, w_res_acc, w_full, w_timeout;

    assign w_xfer      = (r_state == WR) || (r_state == RD);
    assign w_last_word = (r_word_cnt == LAST_WORD);
    assign w_pix_acc   = (r_state == FILL) && pix_valid;
    assign w_res_acc   = (r_state == EMIT) && res_ready;
    // ack wins over a timeout landing in the same cycle
    assign w_timeout   = TO_EN && w_xfer && !ack_i && (r_to == TO_W'(ACK_TIMEOUT - 1));

    pix_pack4 u_pack (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_mode  ((r_state == RD) || (r_state == EMIT)),
        .i_push  (w_pix_acc || w_res_acc),
        .i_load  ((r_state == RD) && ack_i),
        .i_byte  (pix_data),
        .i_word  (dat_i),
        .o_word  (dat_o),
        .o_byte  (res_data),
        .o_full  (w_full)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (frame_go) w_next = FILL;
            FILL:      if (w_pix_acc && w_full) w_next = WR;
            WR:        if (ack_i) w_next = w_last_word ? KICK : FILL;
                       else if (w_timeout) w_next = IDLE;
            KICK:      w_next = WAIT_DONE;
            WAIT_DONE: if (done_i) w_next = RD;
            RD:        if (ack_i) w_next = EMIT;
                       else if (w_timeout) w_next = IDLE;
            EMIT:      if (w_res_acc && w_full) w_next = w_last_word ? IDLE : RD;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        pix_ready = (r_state == FILL);
        cyc_o     = w_xfer;
        stb_o     = w_xfer;
        we_o      = (r_state == WR);
        start_o   = (r_state == KICK);
        res_valid = (r_state == EMIT);
        adr_o     = (r_state == RD) ? RES_BASE + ADR_W'(r_word_cnt)
                                    : IMG_BASE + ADR_W'(r_word_cnt);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_word_cnt   <= '0;
            r_to         <= '0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_res_acc && w_full && w_last_word;
            r_err        <= r_err || w_timeout;
            r_to         <= (w_xfer && !ack_i) ? r_to + TO_W'(1) : '0;
            if ((r_state == IDLE && frame_go) || (r_state == WAIT_DONE && done_i))
                r_word_cnt <= '0;
            else if (r_state == WR && ack_i && !w_last_word)
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            else if (w_res_acc && w_full)
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + CNT_W'(1);
        end
    end

    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_sobel_frame_host.sv
// Scoreboard bench for sobel_frame_host on an 8x2 frame with a modelled bus slave and result sink.
module tb_sobel_frame_host;

    localparam int W = 8, H = 2, NW = W * H / 4;
    localparam logic [21:0] IMGB = 22'h000000, RESB = 22'h020000;

    logic        clk_i = 0, rst_i = 0, frame_go = 0, pix_valid = 0, res_ready = 0;
    logic        ack_i = 0, done_i = 0;
    logic [7:0]  pix_data = 0;
    logic [31:0] dat_i = 0;
    logic        busy, frame_done, pix_ready, res_valid, cyc_o, stb_o, we_o, start_o, err;
    logic [7:0]  res_data;
    logic [21:0] adr_o;
    logic [31:0] dat_o;

    sobel_frame_host #(
        .WIDTH(W), .HEIGHT(H), .ADR_W(22), .IMG_BASE(IMGB), .RES_BASE(RESB), .ACK_TIMEOUT(15)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_go(frame_go), .busy(busy), .frame_done(frame_done),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .start_o(start_o), .done_i(done_i), .err(err)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [21:0] adr; logic [31:0] dat; } wr_t;
    wr_t         wq[$];
    logic [7:0]  bq[$];
    logic [31:0] res_mem[4];
    logic [7:0]  px[NW*4];
    int n_tot = 0, n_bad = 0, dly = 0;
    int n_wr = 0, n_rd = 0, n_start = 0, n_fd = 0, n_res = 0, t_go = 0, t_start = 0;
    bit tog = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus slave: ack after dly wait cycles, checks held request and scoreboards the transfer.
    initial begin : slave
        int cnt;
        logic [54:0] held;
        wr_t e;
        cnt = 0;
        forever begin
            @(negedge clk_i);
            if (ack_i) begin
                ack_i = 0;
                cnt = 0;
            end else if (cyc_o) begin
                if (cnt == 0) held = {we_o, adr_o, dat_o};
                else chk("hold", {we_o, adr_o, dat_o}, held);
                chk("stb", stb_o, 1);
                if (cnt >= dly) begin
                    ack_i = 1;
                    if (we_o) begin
                        n_wr++;
                        chk("wr_pix_ready", pix_ready, 0);
                        if (wq.size() > 0) begin
                            e = wq.pop_front();
                            chk("wr_adr", adr_o, e.adr);
                            chk("wr_dat", dat_o, e.dat);
                        end
                    end else begin
                        chk("rd_adr", adr_o, RESB + 22'(n_rd));
                        dat_i = res_mem[n_rd % 4];
                        n_rd++;
                    end
                end
                cnt++;
            end else cnt = 0;
        end
    end

    // Result sink: ready applies to the next edge, so update it before sampling.
    initial begin : sink
        forever begin
            @(negedge clk_i);
            res_ready = tog ? ~res_ready : 1'b1;
            if (res_valid && res_ready) begin
                n_res++;
                if (bq.size() > 0) chk("res_byte", res_data, bq.pop_front());
            end
        end
    end

    initial begin : mon
        forever begin
            @(negedge clk_i);
            if (start_o) begin n_start++; t_start = cyc; end
            if (frame_done) n_fd++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic plan_frame(input int kind);
        for (int i = 0; i < NW * 4; i++) px[i] = (kind == 0) ? 8'(i) : 8'($urandom);
        wq.delete();
        bq.delete();
        for (int w = 0; w < NW; w++)
            wq.push_back('{IMGB + 22'(w), {px[4*w+3], px[4*w+2], px[4*w+1], px[4*w]}});
        if (kind == 0) begin
            res_mem[0] = 32'hDDCCBBAA; res_mem[1] = 32'h44332211;
            res_mem[2] = 32'h88776655; res_mem[3] = 32'hCCBBAA99;
        end else
            for (int w = 0; w < 4; w++) res_mem[w] = $urandom;
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++) bq.push_back(res_mem[w % 4][8*b +: 8]);
        n_wr = 0; n_rd = 0; n_start = 0; n_fd = 0; n_res = 0;
    endtask

    task automatic send_pix(input logic [7:0] p);
        int n;
        n = 0;
        pix_valid = 1;
        pix_data  = p;
        while (!pix_ready && n < 100) begin @(negedge clk_i); n++; end
        if (n >= 100) chk("pix_ready_wait", pix_ready, 1);
        @(negedge clk_i);
        pix_valid = 0;
    endtask

    task automatic go();
        frame_go = 1;
        t_go = cyc;
        @(negedge clk_i);
        frame_go = 0;
    endtask

    task automatic pulse_done();
        int n;
        n = 0;
        while (n_start == 0 && n < 200) begin @(negedge clk_i); n++; end
        repeat (3) @(negedge clk_i);
        chk("wait_cyc", cyc_o, 0);
        chk("wait_busy", busy, 1);
        chk("rd_before_done", n_rd, 0);
        done_i = 1;
        @(negedge clk_i);
        done_i = 0;
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while (!frame_done && n < 500) begin @(negedge clk_i); n++; end
        chk("fd_seen", frame_done, 1);
        chk("fd_busy", busy, 0);
        @(negedge clk_i);
        chk("fd_width", frame_done, 0);
        chk("fd_busy_next", busy, 0);
        chk("n_wr", n_wr, NW);
        chk("n_rd", n_rd, NW);
        chk("n_start", n_start, 1);
        chk("n_fd", n_fd, 1);
        chk("n_res", n_res, 4 * NW);
    endtask

    initial begin : main
        int n;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy, 0);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_adr", adr_o, IMGB);
        chk("rst_dat", dat_o, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_start", start_o, 0);
        chk("rst_err", err, 0);
        rst_i = 1;
        @(negedge clk_i);

        // reset while a write to word 1 is waiting for ack
        plan_frame(0);
        dly = 0;
        go();
        for (int i = 0; i < 4; i++) send_pix(px[i]);
        dly = 40;
        for (int i = 4; i < 8; i++) send_pix(px[i]);
        @(negedge clk_i);
        chk("abort_pre_cyc", cyc_o, 1);
        chk("abort_pre_adr", adr_o, IMGB + 22'd1);
        rst_i = 0;
        @(negedge clk_i);
        rst_i = 1;
        chk("abort_cyc", cyc_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_adr", adr_o, IMGB);
        chk("abort_we", we_o, 0);
        chk("abort_n_wr", n_wr, 1);
        @(negedge clk_i);

        // ramp frame, slow slave, done_i held during fill, toggling sink, go ignored in EMIT
        plan_frame(0);
        dly = 3;
        tog = 1;
        done_i = 1;
        go();
        for (int i = 0; i < NW * 4; i++) send_pix(px[i]);
        done_i = 0;
        pulse_done();
        n = 0;
        while (!res_valid && n < 200) begin @(negedge clk_i); n++; end
        chk("emit_seen", res_valid, 1);
        frame_go = 1;
        repeat (2) @(negedge clk_i);
        frame_go = 0;
        finish_frame();
        repeat (2) @(negedge clk_i);
        chk("go_ignored", busy, 0);

        // random frame, zero-wait slave: 5 cycles per word into KICK
        plan_frame(1);
        dly = 0;
        tog = 0;
        go();
        for (int i = 0; i < NW * 4; i++) send_pix(px[i]);
        pulse_done();
        chk("throughput", t_start - t_go, 5 * NW + 1);
        finish_frame();

`ifdef SOBEL_FRAME_HOST_TIMEOUT_EN
        plan_frame(0);
        dly = 100000;
        go();
        for (int i = 0; i < 4; i++) send_pix(px[i]);
        n = 0;
        while (cyc_o && n < 100) begin n++; @(negedge clk_i); end
        chk("to_cycles", n, 15);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        repeat (5) @(negedge clk_i);
        chk("to_err_sticky", err, 1);
        chk("to_fd", n_fd, 0);
        rst_i = 0;
        @(negedge clk_i);
        rst_i = 1;
        chk("to_err_rst", err, 0);
`else
        chk("err_off", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
